// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (A = CPU, B = DMA/debug) round-robin arbiter in
// front of a single-ported memory with a fixed read latency.
// Every output comes straight from a flop. Address all-ones halts further
// grants until reset.
module mem_arbiter #(
  parameter int WORDSIZE = 16,
  parameter int ADDRW    = 16,
  parameter int RD_LAT   = 1    // memory read latency, 1..7 cycles
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                A_req,
  input  logic                A_wr,
  input  logic [ADDRW-1:0]    A_addr,
  input  logic [WORDSIZE-1:0] A_wdata,
  output logic                A_gnt,
  output logic                A_rvalid,
  output logic [WORDSIZE-1:0] A_rdata,
  input  logic                B_req,
  input  logic                B_wr,
  input  logic [ADDRW-1:0]    B_addr,
  input  logic [WORDSIZE-1:0] B_wdata,
  output logic                B_gnt,
  output logic                B_rvalid,
  output logic [WORDSIZE-1:0] B_rdata,
  output logic [ADDRW-1:0]    Addr,
  output logic                RD,
  output logic                WR,
  output logic [WORDSIZE-1:0] DataOut,
  input  logic [WORDSIZE-1:0] DataIn,
  output logic                Halt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  // Final RWAIT count: data is captured when the counter reaches this value.
  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t                     state_reg, state_next;
  logic                       prio_reg, prio_next;      // 0 = A holds priority, 1 = B
  logic [2:0]                 cnt_reg, cnt_next;
  logic                       halt_reg, halt_next;
  logic                       port_reg, port_next;      // port owning the current access
  logic                       wr_lat_reg, wr_lat_next;  // current access is a write
  logic [1:0]                 gnt_reg, gnt_next;
  logic [1:0]                 rvalid_reg, rvalid_next;
  logic [ADDRW-1:0]           addr_reg, addr_next;
  logic                       rd_reg, rd_next;
  logic                       wr_reg, wr_next;
  logic [WORDSIZE-1:0]        dout_reg, dout_next;
  logic                       capture;

  // Requester fields gathered into port-indexed vectors (index 0 = A, 1 = B).
  logic [1:0]                 req_vec;
  logic [1:0]                 wr_vec;
  logic [1:0][ADDRW-1:0]      addr_vec;
  logic [1:0][WORDSIZE-1:0]   wdata_vec;
  logic                       grant_port;

  assign req_vec   = {B_req, A_req};
  assign wr_vec    = {B_wr, A_wr};
  assign addr_vec  = {B_addr, A_addr};
  assign wdata_vec = {B_wdata, A_wdata};

  // Pointer only matters on contention; a lone requester always wins.
  assign grant_port = (req_vec == 2'b11) ? prio_reg : req_vec[1];

  // Next-state and next-output logic; outputs default to their idle values.
  always_comb begin
    state_next  = state_reg;
    prio_next   = prio_reg;
    cnt_next    = cnt_reg;
    halt_next   = halt_reg;
    port_next   = port_reg;
    wr_lat_next = wr_lat_reg;
    gnt_next    = 2'b00;
    rvalid_next = 2'b00;
    addr_next   = '0;
    rd_next     = 1'b0;
    wr_next     = 1'b0;
    dout_next   = '0;
    capture     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!halt_reg && (req_vec != 2'b00)) begin
          state_next            = ACCESS;
          port_next             = grant_port;
          wr_lat_next           = wr_vec[grant_port];
          prio_next             = ~grant_port;
          gnt_next[grant_port]  = 1'b1;
          addr_next             = addr_vec[grant_port];
          rd_next               = ~wr_vec[grant_port];
          wr_next               = wr_vec[grant_port];
          dout_next             = wr_vec[grant_port] ? wdata_vec[grant_port] : '0;
          if (addr_vec[grant_port] == '1) begin
            halt_next = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (wr_lat_reg) begin
          state_next = IDLE;
        end else begin
          state_next = RWAIT;
          cnt_next   = '0;
        end
      end
      RWAIT: begin
        if (cnt_reg == LAST_CNT) begin
          state_next            = IDLE;
          capture               = 1'b1;
          rvalid_next[port_reg] = 1'b1;
          cnt_next              = '0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      cnt_reg    <= '0;
      halt_reg   <= 1'b0;
      port_reg   <= 1'b0;
      wr_lat_reg <= 1'b0;
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      addr_reg   <= '0;
      rd_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      prio_reg   <= prio_next;
      cnt_reg    <= cnt_next;
      halt_reg   <= halt_next;
      port_reg   <= port_next;
      wr_lat_reg <= wr_lat_next;
      gnt_reg    <= gnt_next;
      rvalid_reg <= rvalid_next;
      addr_reg   <= addr_next;
      rd_reg     <= rd_next;
      wr_reg     <= wr_next;
      dout_reg   <= dout_next;
    end
  end

  // One read-data holding register per port, so each port keeps its last word.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [WORDSIZE-1:0] rdata_reg;

      // Capture returning memory data for this port only; hold otherwise.
      always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
          rdata_reg <= '0;
        end else if (capture && (port_reg == 1'(gi))) begin
          rdata_reg <= DataIn;
        end
      end
    end
  endgenerate

  assign A_gnt    = gnt_reg[0];
  assign B_gnt    = gnt_reg[1];
  assign A_rvalid = rvalid_reg[0];
  assign B_rvalid = rvalid_reg[1];
  assign A_rdata  = g_port[0].rdata_reg;
  assign B_rdata  = g_port[1].rdata_reg;
  assign Addr     = addr_reg;
  assign RD       = rd_reg;
  assign WR       = wr_reg;
  assign DataOut  = dout_reg;
  assign Halt     = halt_reg;

endmodule
